// File: rtl/instr_encoder.sv
// Program writer for the LFSR machine: turns mnemonic requests into 11-bit
// instruction words and writes them to consecutive imem addresses from 0.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [7:0]        req_arg,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [10:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow,
    output logic              err_arg
);

    localparam logic [2:0] OP_ST        = 3'd0;
    localparam logic [2:0] OP_LD        = 3'd1;
    localparam logic [2:0] OP_INIT_ADDR = 3'd2;
    localparam logic [2:0] OP_ADD_ADDR  = 3'd3;
    localparam logic [2:0] OP_CONFIG    = 3'd4;
    localparam logic [2:0] OP_INIT_L    = 3'd5;
    localparam logic [2:0] OP_RUN       = 3'd6;
    localparam logic [2:0] OP_HALT      = 3'd7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [10:0]       RUN_WORD  = {OP_RUN, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_FULL   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Encoded instruction word for one request
    function automatic logic [10:0] encode_word(input logic [2:0] op, input logic [7:0] arg);
        logic [10:0] w;
        case (op)
            OP_INIT_ADDR, OP_ADD_ADDR, OP_INIT_L: w = {op, arg};
            OP_CONFIG:                            w = {op, 1'b0, arg[6:0]};
            OP_ST, OP_LD, OP_RUN, OP_HALT:        w = {op, 8'h00};
            default:                              w = {op, 8'h00};
        endcase
        return w;
    endfunction

    // High when encoding throws away a set argument bit (run's count is not lost)
    function automatic logic arg_lost(input logic [2:0] op, input logic [7:0] arg);
        logic lost;
        case (op)
            OP_ST, OP_LD, OP_HALT: lost = |arg;
            OP_CONFIG:             lost = arg[7];
            default:               lost = 1'b0;
        endcase
        return lost;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]        rem_q, rem_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [10:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              ready_s;
    logic              accept_s;
    logic              multi_run_s;

    assign ready_s     = !reset && ((state_q == S_IDLE) || (state_q == S_FULL));
    assign accept_s    = req_valid && ready_s;
    assign multi_run_s = (req_op == OP_RUN) && (req_arg > 8'd1);

    // Next-state, write generation and sticky status flags
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    we_d     = 1'b1;
                    addr_d   = wr_ptr_q;
                    wdata_d  = encode_word(req_op, req_arg);
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    count_d  = (count_q == DEPTH) ? count_q : count_q + (ADDR_W+1)'(1);
                    err_d    = err_q | arg_lost(req_op, req_arg);
                    if (req_op == OP_HALT) begin
                        done_d  = 1'b1;
                        state_d = S_HALTED;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // A multi-word run that starts on the last slot loses its tail
                        ovf_d   = ovf_q | multi_run_s;
                        state_d = S_FULL;
                    end else if (multi_run_s) begin
                        rem_d   = req_arg - 8'd1;
                        state_d = S_EXPAND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXPAND: begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = RUN_WORD;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = (count_q == DEPTH) ? count_q : count_q + (ADDR_W+1)'(1);
                rem_d    = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                    state_d = (wr_ptr_q == LAST_ADDR) ? S_FULL : S_IDLE;
                end else if (wr_ptr_q == LAST_ADDR) begin
                    ovf_d   = 1'b1;
                    state_d = S_FULL;
                end else begin
                    state_d = S_EXPAND;
                end
            end
            S_FULL: begin
                if (accept_s) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rem_q    <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 11'h000;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = ready_s;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign err_arg    = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for encoding,
// run expansion, halt and reset abort, plus a 2-bit-address instance for overflow.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A, ADDR_W = 8
    logic        ra, va, rdya, wea, donea, ovfa, erra;
    logic [2:0]  opa;
    logic [7:0]  arga, addra;
    logic [10:0] wda;
    logic [8:0]  cnta;

    // Instance B, ADDR_W = 2
    logic        rb, vb, rdyb, web, doneb, ovfb, errb;
    logic [2:0]  opb;
    logic [7:0]  argb;
    logic [1:0]  addrb;
    logic [10:0] wdb;
    logic [2:0]  cntb;

    instr_encoder #(.ADDR_W(8)) dut_a (
        .clk(clk), .reset(ra), .req_valid(va), .req_ready(rdya), .req_op(opa), .req_arg(arga),
        .imem_we(wea), .imem_addr(addra), .imem_wdata(wda), .count(cnta),
        .done(donea), .overflow(ovfa), .err_arg(erra)
    );

    instr_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(rb), .req_valid(vb), .req_ready(rdyb), .req_op(opb), .req_arg(argb),
        .imem_we(web), .imem_addr(addrb), .imem_wdata(wdb), .count(cntb),
        .done(doneb), .overflow(ovfb), .err_arg(errb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; returns at the negedge where its write is visible
    task automatic send_a(input logic [2:0] op, input logic [7:0] arg);
        @(negedge clk);
        va = 1'b1; opa = op; arga = arg;
        @(negedge clk);
        va = 1'b0; opa = 3'd0; arga = 8'h00;
    endtask

    task automatic send_b(input logic [2:0] op, input logic [7:0] arg);
        @(negedge clk);
        vb = 1'b1; opb = op; argb = arg;
        @(negedge clk);
        vb = 1'b0; opb = 3'd0; argb = 8'h00;
    endtask

    task automatic chk_write_a(input string tag, input logic [7:0] addr, input logic [10:0] wd);
        chk({tag, "_we"}, {31'd0, wea}, 32'd1);
        chk({tag, "_addr"}, {24'd0, addra}, {24'd0, addr});
        chk({tag, "_wdata"}, {21'd0, wda}, {21'd0, wd});
    endtask

    task automatic chk_write_b(input string tag, input logic [1:0] addr, input logic [10:0] wd);
        chk({tag, "_we"}, {31'd0, web}, 32'd1);
        chk({tag, "_addr"}, {30'd0, addrb}, {30'd0, addr});
        chk({tag, "_wdata"}, {21'd0, wdb}, {21'd0, wd});
    endtask

    initial begin
        ra = 1'b1; va = 1'b0; opa = 3'd0; arga = 8'h00;
        rb = 1'b1; vb = 1'b0; opb = 3'd0; argb = 8'h00;

        // ---- 1: reset and init_addr
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_low", {31'd0, rdya}, 32'd0);
        ra = 1'b0; rb = 1'b0;
        @(negedge clk);
        chk("rst_we", {31'd0, wea}, 32'd0);
        chk("rst_addr", {24'd0, addra}, 32'd0);
        chk("rst_wdata", {21'd0, wda}, 32'd0);
        chk("rst_count", {23'd0, cnta}, 32'd0);
        chk("rst_flags", {29'd0, donea, ovfa, erra}, 32'd0);
        chk("rst_ready_high", {31'd0, rdya}, 32'd1);

        send_a(3'd2, 8'h3C);
        chk_write_a("init_addr", 8'd0, 11'h23C);
        chk("init_addr_count", {23'd0, cnta}, 32'd1);
        chk("init_addr_err", {31'd0, erra}, 32'd0);
        @(negedge clk);
        chk("idle_we_low", {31'd0, wea}, 32'd0);

        // ---- 2: config drops arg[7]; st keeps err_arg sticky
        send_a(3'd4, 8'hFF);
        chk_write_a("config", 8'd1, 11'h47F);
        chk("config_err", {31'd0, erra}, 32'd1);
        send_a(3'd0, 8'h00);
        chk_write_a("st", 8'd2, 11'h000);
        chk("st_err_sticky", {31'd0, erra}, 32'd1);
        send_a(3'd1, 8'h00);
        chk_write_a("ld", 8'd3, 11'h100);
        send_a(3'd3, 8'h05);
        chk_write_a("add_addr", 8'd4, 11'h305);

        // ---- 3: run 3 from wr_ptr 5, then run 0
        @(negedge clk);
        va = 1'b1; opa = 3'd6; arga = 8'd3;
        @(negedge clk);
        va = 1'b0;
        chk_write_a("run3_w0", 8'd5, 11'h600);
        chk("run3_ready0", {31'd0, rdya}, 32'd0);
        @(negedge clk);
        chk_write_a("run3_w1", 8'd6, 11'h600);
        chk("run3_ready1", {31'd0, rdya}, 32'd0);
        @(negedge clk);
        chk_write_a("run3_w2", 8'd7, 11'h600);
        chk("run3_ready2", {31'd0, rdya}, 32'd1);
        @(negedge clk);
        chk("run3_end_we", {31'd0, wea}, 32'd0);
        chk("run3_count", {23'd0, cnta}, 32'd8);

        send_a(3'd6, 8'd0);
        chk_write_a("run0", 8'd8, 11'h600);
        chk("run0_ready", {31'd0, rdya}, 32'd1);
        @(negedge clk);
        chk("run0_single", {31'd0, wea}, 32'd0);
        chk("run0_count", {23'd0, cnta}, 32'd9);

        send_a(3'd5, 8'hA5);
        chk_write_a("init_l", 8'd9, 11'h5A5);

        // ---- 4: halt
        send_a(3'd7, 8'h00);
        chk_write_a("halt", 8'd10, 11'h700);
        chk("halt_done", {31'd0, donea}, 32'd1);
        chk("halt_ready", {31'd0, rdya}, 32'd0);
        va = 1'b1; opa = 3'd2; arga = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halted_no_we", {31'd0, wea}, 32'd0);
        end
        va = 1'b0;
        chk("halted_count", {23'd0, cnta}, 32'd11);
        chk("halted_done", {31'd0, donea}, 32'd1);

        // ---- 5: small memory overflow on instance B
        for (int i = 0; i < 4; i++) begin
            send_b(3'd2, 8'(i + 1));
            chk_write_b("fill", 2'(i), 11'h200 | 11'(i + 1));
        end
        chk("fill_no_ovf", {31'd0, ovfb}, 32'd0);
        chk("full_ready", {31'd0, rdyb}, 32'd1);
        send_b(3'd2, 8'h05);
        chk("fifth_no_we", {31'd0, web}, 32'd0);
        chk("fifth_ovf", {31'd0, ovfb}, 32'd1);
        chk("fifth_count", {29'd0, cntb}, 32'd4);
        send_b(3'd7, 8'h00);
        chk("full_halt_done", {31'd0, doneb}, 32'd0);

        @(negedge clk);
        rb = 1'b1;
        @(negedge clk);
        rb = 1'b0;
        send_b(3'd2, 8'h01);
        send_b(3'd2, 8'h02);
        @(negedge clk);
        vb = 1'b1; opb = 3'd6; argb = 8'd6;
        @(negedge clk);
        vb = 1'b0;
        chk_write_b("ovrun_w0", 2'd2, 11'h600);
        chk("ovrun_ovf0", {31'd0, ovfb}, 32'd0);
        @(negedge clk);
        chk_write_b("ovrun_w1", 2'd3, 11'h600);
        chk("ovrun_ovf1", {31'd0, ovfb}, 32'd1);
        @(negedge clk);
        chk("ovrun_stop", {31'd0, web}, 32'd0);
        chk("ovrun_count", {29'd0, cntb}, 32'd4);

        // ---- 6: reset aborts an expansion on instance A
        @(negedge clk);
        ra = 1'b1;
        @(negedge clk);
        ra = 1'b0;
        send_a(3'd6, 8'd5);
        chk_write_a("abort_w0", 8'd0, 11'h600);
        @(negedge clk);
        chk_write_a("abort_w1", 8'd1, 11'h600);
        ra = 1'b1;
        #1;
        chk("abort_ready_in_rst", {31'd0, rdya}, 32'd0);
        @(negedge clk);
        chk("abort_we", {31'd0, wea}, 32'd0);
        chk("abort_addr", {24'd0, addra}, 32'd0);
        chk("abort_wdata", {21'd0, wda}, 32'd0);
        chk("abort_count", {23'd0, cnta}, 32'd0);
        ra = 1'b0;
        @(negedge clk);
        chk("abort_no_we", {31'd0, wea}, 32'd0);
        chk("abort_ready", {31'd0, rdya}, 32'd1);
        send_a(3'd2, 8'h01);
        chk_write_a("after_abort", 8'd0, 11'h201);
        chk("after_abort_count", {23'd0, cnta}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
